param_combo_lock: RTL and testbench
===================================

Name: param_combo_lock

Overview:
Parametrised successor to the fixed 6-digit lab combination lock. It accepts decimal digits one per strobe and compares them against a stored NUM_DIGITS-digit code. It tracks failed attempts and enters a timed lockout after MAX_TRIES failures. While open, a new code can be programmed. Seven-segment decoding stays in the top level, which drives displays from the status outputs.

Parameters:
NUM_DIGITS, 6, code length in decimal digits (2..8)
RESET_CODE, 32'h00722297, code loaded at reset; low NUM_DIGITS nibbles used, MS nibble = first digit
MAX_TRIES, 3, consecutive failed attempts that trigger lockout (>=1)
LOCKOUT_CYCLES, 16, lockout duration in clk cycles (>=1)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset; asynchronous, active-low
digit_in  input  4  BCD digit from SW[3:0]
digit_valid  input  1  one-cycle strobe: digit_in is presented this cycle
relock  input  1  close lock / abort programming
prog_start  input  1  enter code-programming mode (honoured only when open)
unlocked  output  1  lock open
locked_out  output  1  lockout active
programming  output  1  in PROG state
err_digit  output  1  one-cycle pulse: strobed digit >9
mode  output  2  0=ENTRY, 1=OPEN, 2=LOCKOUT, 3=PROG
entry_idx  output  $clog2(NUM_DIGITS)  digits accepted in current attempt/program sequence
fail_count  output  $clog2(MAX_TRIES+1)  consecutive failed attempts

Behaviour:
- All outputs registered; rst low asynchronously forces: mode=ENTRY, entry_idx=0, fail_count=0, mismatch flag=0, unlocked=0, locked_out=0, programming=0, err_digit=0, stored code=RESET_CODE, lockout counter=0.
- Accepted digit: digit_valid=1 and digit_in<=9. If digit_valid=1 and digit_in>9 in ENTRY or PROG: err_digit=1 next cycle; entry_idx and flags unchanged.
- ENTRY: accepted digit compared with code nibble [NUM_DIGITS-1-entry_idx]; mismatch flag sticky-ORed; entry_idx++.
  - On the NUM_DIGITS-th accepted digit, with full-code match (flag and current compare both clean): next cycle mode=OPEN, unlocked=1, entry_idx=0, fail_count=0.
  - Otherwise, with mismatch: entry_idx=0, flag cleared, fail_count++. If the new fail_count==MAX_TRIES: mode=LOCKOUT, locked_out=1, counter=LOCKOUT_CYCLES. Else stay in ENTRY.
  - Failure is never signalled before all NUM_DIGITS digits are taken, so the failing position is not revealed.
  - relock in ENTRY clears entry_idx and the flag; fail_count is kept.
- LOCKOUT: digit_valid ignored (no err_digit); counter decrements each cycle. When the counter reaches 1: next cycle mode=ENTRY, locked_out=0, fail_count=0. Duration is exactly LOCKOUT_CYCLES cycles.
- OPEN: digits ignored.
  - relock: next cycle mode=ENTRY, unlocked=0.
  - prog_start: next cycle mode=PROG, programming=1, unlocked stays 1, entry_idx=0.
  - relock and prog_start in the same cycle: relock wins.
- PROG: accepted digits are shifted into a shadow register; entry_idx++.
  - On the NUM_DIGITS-th digit: shadow (with last digit) is committed to the stored code; next cycle mode=OPEN, programming=0.
  - relock aborts: shadow is discarded, stored code is unchanged, mode=ENTRY, unlocked=0.
  - relock wins over a simultaneous final digit.
- entry_idx wraps to 0 only via the completion or abort rules above; it never exceeds NUM_DIGITS-1.
- Async reset mid-sequence (any state) returns to the reset state and restores RESET_CODE. Programmed codes are lost.

Test Plan:
- Reset, then strobe 7,2,2,2,9,7 (one per 2 cycles) -> entry_idx steps 1..5,0; unlocked=1, mode=1 the cycle after the 6th strobe; fail_count=0.
- Strobe 7,3,2,2,9,7 -> unlocked stays 0 throughout; after 6th strobe fail_count=1, mode=0, entry_idx=0.
- Three wrong 6-digit attempts -> locked_out=1, mode=2 for exactly 16 cycles; strobes of 7,2,2,2,9,7 during lockout have no effect; then mode=0, fail_count=0; a correct code then opens.
- In ENTRY after 2 digits, strobe digit_in=11 -> err_digit pulses 1 cycle; entry_idx stays 2; completing the correct code still opens.
- Open, then prog_start, then 1,2,3,4,5,6, then relock -> 7,2,2,2,9,7 fails (fail_count=1); 1,2,3,4,5,6 opens. Repeat with relock after 3 programmed digits -> old code still valid.
- Drive rst low asynchronously (between clock edges) after 4 correct digits, and again in OPEN -> all outputs zero immediately; RESET_CODE valid after release.

Source files
------------

// File: rtl/param_combo_lock.sv
// Parametrised decimal combination lock: digit-by-digit code entry, failed-attempt
// lockout and in-place code reprogramming while open.
module param_combo_lock #(
  parameter int unsigned NUM_DIGITS     = 6,
  parameter logic [31:0] RESET_CODE     = 32'h00722297,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [3:0]                       digit_in,
  input  logic                             digit_valid,
  input  logic                             relock,
  input  logic                             prog_start,
  output logic                             unlocked,
  output logic                             locked_out,
  output logic                             programming,
  output logic                             err_digit,
  output logic [1:0]                       mode,
  output logic [$clog2(NUM_DIGITS)-1:0]    entry_idx,
  output logic [$clog2(MAX_TRIES+1)-1:0]   fail_count
);

  localparam int unsigned IdxW  = $clog2(NUM_DIGITS);
  localparam int unsigned CodeW = 4 * NUM_DIGITS;
  localparam int unsigned FcW   = $clog2(MAX_TRIES + 1);
  localparam int unsigned CntW  = $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_DIGITS - 1);
  localparam logic [FcW-1:0]  MaxFail  = FcW'(MAX_TRIES);
  localparam logic [CntW-1:0] LockInit = CntW'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    StEntry   = 2'd0,
    StOpen    = 2'd1,
    StLockout = 2'd2,
    StProg    = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [FcW-1:0]   fail_q, fail_d;
  logic             mis_q, mis_d;
  logic             unlocked_q, unlocked_d;
  logic             locked_out_q, locked_out_d;
  logic             programming_q, programming_d;
  logic             err_q, err_d;
  logic [CodeW-1:0] code_q, code_d;
  logic [CodeW-1:0] shadow_q, shadow_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [3:0] cur_nib;
  logic       digit_ok;
  logic       digit_bad;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    fail_d        = fail_q;
    mis_d         = mis_q;
    unlocked_d    = unlocked_q;
    locked_out_d  = locked_out_q;
    programming_d = programming_q;
    err_d         = 1'b0;
    code_d        = code_q;
    shadow_d      = shadow_q;
    cnt_d         = cnt_q;

    // First digit entered is the most significant nibble of the code.
    cur_nib = 4'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IdxW'(i)) cur_nib = code_q[4*(NUM_DIGITS-1-i) +: 4];
    end

    digit_ok  = digit_valid && (digit_in <= 4'd9);
    digit_bad = digit_valid && (digit_in > 4'd9);

    unique case (state_q)
      StEntry: begin
        if (relock) begin
          idx_d = '0;
          mis_d = 1'b0;
        end else if (digit_bad) begin
          err_d = 1'b1;
        end else if (digit_ok) begin
          if (idx_q == LastIdx) begin
            idx_d = '0;
            mis_d = 1'b0;
            if (!mis_q && (digit_in == cur_nib)) begin
              state_d    = StOpen;
              unlocked_d = 1'b1;
              fail_d     = '0;
            end else begin
              fail_d = fail_q + FcW'(1);
              if (fail_d == MaxFail) begin
                state_d      = StLockout;
                locked_out_d = 1'b1;
                cnt_d        = LockInit;
              end
            end
          end else begin
            idx_d = idx_q + IdxW'(1);
            mis_d = mis_q | (digit_in != cur_nib);
          end
        end
      end

      StLockout: begin
        if (cnt_q == CntW'(1)) begin
          state_d      = StEntry;
          locked_out_d = 1'b0;
          fail_d       = '0;
          cnt_d        = '0;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end

      StOpen: begin
        if (relock) begin
          state_d    = StEntry;
          unlocked_d = 1'b0;
        end else if (prog_start) begin
          state_d       = StProg;
          programming_d = 1'b1;
          idx_d         = '0;
          shadow_d      = '0;
        end
      end

      StProg: begin
        if (relock) begin
          state_d       = StEntry;
          unlocked_d    = 1'b0;
          programming_d = 1'b0;
          idx_d         = '0;
          shadow_d      = '0;
        end else if (digit_bad) begin
          err_d = 1'b1;
        end else if (digit_ok) begin
          shadow_d = {shadow_q[CodeW-5:0], digit_in};
          if (idx_q == LastIdx) begin
            code_d        = shadow_d;
            idx_d         = '0;
            state_d       = StOpen;
            programming_d = 1'b0;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end

      default: state_d = StEntry;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StEntry;
      idx_q         <= '0;
      fail_q        <= '0;
      mis_q         <= 1'b0;
      unlocked_q    <= 1'b0;
      locked_out_q  <= 1'b0;
      programming_q <= 1'b0;
      err_q         <= 1'b0;
      code_q        <= RESET_CODE[CodeW-1:0];
      shadow_q      <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      fail_q        <= fail_d;
      mis_q         <= mis_d;
      unlocked_q    <= unlocked_d;
      locked_out_q  <= locked_out_d;
      programming_q <= programming_d;
      err_q         <= err_d;
      code_q        <= code_d;
      shadow_q      <= shadow_d;
      cnt_q         <= cnt_d;
    end
  end

  assign unlocked    = unlocked_q;
  assign locked_out  = locked_out_q;
  assign programming = programming_q;
  assign err_digit   = err_q;
  assign mode        = state_q;
  assign entry_idx   = idx_q;
  assign fail_count  = fail_q;

endmodule

// File: tb/tb_param_combo_lock.sv
// Directed self-checking bench for param_combo_lock with default parameters.
module tb_param_combo_lock;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       digit_valid = 1'b0;
  logic       relock = 1'b0;
  logic       prog_start = 1'b0;
  logic       unlocked, locked_out, programming, err_digit;
  logic [1:0] mode;
  logic [2:0] entry_idx;
  logic [1:0] fail_count;

  int total = 0;
  int bad   = 0;

  param_combo_lock dut (
    .clk         (clk),
    .rst         (rst),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .relock      (relock),
    .prog_start  (prog_start),
    .unlocked    (unlocked),
    .locked_out  (locked_out),
    .programming (programming),
    .err_digit   (err_digit),
    .mode        (mode),
    .entry_idx   (entry_idx),
    .fail_count  (fail_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one digit for one edge; outputs reflect that edge on return.
  task automatic strobe(input logic [3:0] d);
    digit_in    = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic enter_code(input logic [23:0] c);
    for (int i = 0; i < 6; i++) begin
      strobe(c[23-4*i -: 4]);
      tick();
    end
  endtask

  task automatic pulse_relock();
    relock = 1'b1;
    tick();
    relock = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL reset_mode got=%0d want=0", mode); end
    total++; if (entry_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d want=0", entry_idx); end
    total++; if (fail_count !== 2'd0) begin bad++; $display("FAIL reset_fail got=%0d want=0", fail_count); end
    total++; if ({unlocked, locked_out, programming, err_digit} !== 4'b0)
      begin bad++; $display("FAIL reset_flags got=%b want=0000", {unlocked, locked_out, programming, err_digit}); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_open();
    logic [23:0] c = 24'h722297;
    for (int i = 0; i < 6; i++) begin
      strobe(c[23-4*i -: 4]);
      total++;
      if (entry_idx !== ((i < 5) ? 3'(i + 1) : 3'd0))
        begin bad++; $display("FAIL open_idx%0d got=%0d want=%0d", i, entry_idx, (i < 5) ? i + 1 : 0); end
      total++;
      if (unlocked !== (i == 5))
        begin bad++; $display("FAIL open_unlocked%0d got=%0b want=%0b", i, unlocked, i == 5); end
      tick();
    end
    total++; if (mode !== 2'd1) begin bad++; $display("FAIL open_mode got=%0d want=1", mode); end
    total++; if (fail_count !== 2'd0) begin bad++; $display("FAIL open_fail got=%0d want=0", fail_count); end
    pulse_relock();
    total++; if (mode !== 2'd0 || unlocked !== 1'b0)
      begin bad++; $display("FAIL relock_open got mode=%0d unl=%0b want 0/0", mode, unlocked); end
  endtask

  task automatic test_wrong();
    logic [23:0] c = 24'h732297;
    for (int i = 0; i < 6; i++) begin
      strobe(c[23-4*i -: 4]);
      total++; if (unlocked !== 1'b0) begin bad++; $display("FAIL wrong_unlocked%0d got=%0b want=0", i, unlocked); end
      tick();
    end
    total++; if (fail_count !== 2'd1) begin bad++; $display("FAIL wrong_fail got=%0d want=1", fail_count); end
    total++; if (mode !== 2'd0) begin bad++; $display("FAIL wrong_mode got=%0d want=0", mode); end
    total++; if (entry_idx !== 3'd0) begin bad++; $display("FAIL wrong_idx got=%0d want=0", entry_idx); end
  endtask

  task automatic test_lockout();
    logic [23:0] c = 24'h722297;
    enter_code(24'h111111);
    total++; if (fail_count !== 2'd2) begin bad++; $display("FAIL lock_fail2 got=%0d want=2", fail_count); end
    // Third failure: check state immediately after the final strobe edge.
    for (int i = 0; i < 5; i++) begin
      strobe(4'd0);
      tick();
    end
    strobe(4'd0);
    total++; if (mode !== 2'd2 || locked_out !== 1'b1)
      begin bad++; $display("FAIL lock_enter got mode=%0d lo=%0b want 2/1", mode, locked_out); end
    total++; if (fail_count !== 2'd3) begin bad++; $display("FAIL lock_fail3 got=%0d want=3", fail_count); end
    for (int k = 1; k < 16; k++) begin
      digit_in    = (k == 7) ? 4'd11 : c[23-4*(k%6) -: 4];
      digit_valid = 1'b1;
      tick();
      total++;
      if (mode !== 2'd2 || locked_out !== 1'b1 || entry_idx !== 3'd0 || err_digit !== 1'b0 || unlocked !== 1'b0)
        begin bad++; $display("FAIL lock_hold%0d got mode=%0d lo=%0b idx=%0d err=%0b want 2/1/0/0",
                              k, mode, locked_out, entry_idx, err_digit); end
    end
    digit_valid = 1'b0;
    tick();
    total++; if (mode !== 2'd0 || locked_out !== 1'b0)
      begin bad++; $display("FAIL lock_exit got mode=%0d lo=%0b want 0/0", mode, locked_out); end
    total++; if (fail_count !== 2'd0) begin bad++; $display("FAIL lock_exit_fail got=%0d want=0", fail_count); end
    enter_code(24'h722297);
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL lock_reopen got=%0b want=1", unlocked); end
    pulse_relock();
  endtask

  task automatic test_err_digit();
    strobe(4'd7); tick();
    strobe(4'd2); tick();
    strobe(4'd11);
    total++; if (err_digit !== 1'b1) begin bad++; $display("FAIL err_pulse got=%0b want=1", err_digit); end
    total++; if (entry_idx !== 3'd2) begin bad++; $display("FAIL err_idx got=%0d want=2", entry_idx); end
    tick();
    total++; if (err_digit !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b want=0", err_digit); end
    strobe(4'd2); tick();
    strobe(4'd2); tick();
    strobe(4'd9); tick();
    strobe(4'd7);
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL err_open got=%0b want=1", unlocked); end
    tick();
    pulse_relock();
  endtask

  task automatic test_prog();
    enter_code(24'h722297);
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    total++; if (mode !== 2'd3 || programming !== 1'b1 || unlocked !== 1'b1 || entry_idx !== 3'd0)
      begin bad++; $display("FAIL prog_enter got mode=%0d prg=%0b unl=%0b idx=%0d want 3/1/1/0",
                            mode, programming, unlocked, entry_idx); end
    enter_code(24'h123456);
    total++; if (mode !== 2'd1 || programming !== 1'b0 || unlocked !== 1'b1)
      begin bad++; $display("FAIL prog_commit got mode=%0d prg=%0b unl=%0b want 1/0/1", mode, programming, unlocked); end
    pulse_relock();
    enter_code(24'h722297);
    total++; if (unlocked !== 1'b0 || fail_count !== 2'd1)
      begin bad++; $display("FAIL prog_oldcode got unl=%0b fail=%0d want 0/1", unlocked, fail_count); end
    enter_code(24'h123456);
    total++; if (unlocked !== 1'b1 || fail_count !== 2'd0)
      begin bad++; $display("FAIL prog_newcode got unl=%0b fail=%0d want 1/0", unlocked, fail_count); end
    // Abort after three programmed digits.
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    strobe(4'd9); tick();
    strobe(4'd8); tick();
    strobe(4'd7); tick();
    total++; if (entry_idx !== 3'd3) begin bad++; $display("FAIL abort_idx got=%0d want=3", entry_idx); end
    pulse_relock();
    total++; if (mode !== 2'd0 || unlocked !== 1'b0 || programming !== 1'b0 || entry_idx !== 3'd0)
      begin bad++; $display("FAIL abort_state got mode=%0d unl=%0b prg=%0b idx=%0d want 0/0/0/0",
                            mode, unlocked, programming, entry_idx); end
    enter_code(24'h123456);
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL abort_keep got=%0b want=1", unlocked); end
    pulse_relock();
  endtask

  task automatic test_async_reset();
    strobe(4'd1); tick();
    strobe(4'd2); tick();
    strobe(4'd3); tick();
    strobe(4'd4); tick();
    total++; if (entry_idx !== 3'd4) begin bad++; $display("FAIL ar_pre_idx got=%0d want=4", entry_idx); end
    #2 rst = 1'b0;
    #1;
    total++; if ({unlocked, locked_out, programming, err_digit, mode, entry_idx, fail_count} !== 11'b0)
      begin bad++; $display("FAIL ar_entry_zero got mode=%0d idx=%0d fail=%0d", mode, entry_idx, fail_count); end
    rst = 1'b1;
    tick();
    enter_code(24'h722297);
    total++; if (unlocked !== 1'b1 || mode !== 2'd1)
      begin bad++; $display("FAIL ar_resetcode got unl=%0b mode=%0d want 1/1", unlocked, mode); end
    #2 rst = 1'b0;
    #1;
    total++; if ({unlocked, locked_out, programming, err_digit, mode, entry_idx, fail_count} !== 11'b0)
      begin bad++; $display("FAIL ar_open_zero got unl=%0b mode=%0d", unlocked, mode); end
    rst = 1'b1;
    tick();
    enter_code(24'h722297);
    total++; if (unlocked !== 1'b1) begin bad++; $display("FAIL ar_reopen got=%0b want=1", unlocked); end
  endtask

  initial begin
    test_reset();
    test_open();
    test_wrong();
    test_lockout();
    test_err_digit();
    test_prog();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
